// File: rtl/rca_pipe_if.sv
// Handshake bundle for rca_pipe: operand input side plus registered result side.
// Carries ovf only when RCA_OVF_EN is defined.
interface rca_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
`ifdef RCA_OVF_EN
    logic             ovf;

    modport master (
        output a, b, cin, in_valid, out_ready,
        input  in_ready, sum, cout, out_valid, ovf
    );
    modport slave (
        input  a, b, cin, in_valid, out_ready,
        output in_ready, sum, cout, out_valid, ovf
    );
`else
    modport master (
        output a, b, cin, in_valid, out_ready,
        input  in_ready, sum, cout, out_valid
    );
    modport slave (
        input  a, b, cin, in_valid, out_ready,
        output in_ready, sum, cout, out_valid
    );
`endif
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: WIDTH bits in STAGES carry-chain segments with valid/ready
// backpressure. Optional signed-overflow output enabled by macro RCA_OVF_EN.
module rca_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic       clk,
    input logic       rst,
    rca_pipe_if.slave bus
);
    localparam int NS = int'(STAGES);
    localparam int CW = int'(WIDTH / STAGES);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] cy_d;
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic              carry;
    int                idx;
`ifdef RCA_OVF_EN
    logic              msb_ci;
    logic              ovf_q;
`endif

    // Stage k consumes what stage k-1 registered; stage 0 consumes the input port.
    assign src_v[0] = bus.in_valid;
    assign src_c[0] = bus.cin;
    assign src_a[0] = bus.a;
    assign src_b[0] = bus.b;
    assign src_r[0] = '0;

    for (genvar k = 1; k < NS; k++) begin : g_link
        assign src_v[k] = vld_q[k-1];
        assign src_c[k] = cy_q[k-1];
        assign src_a[k] = opa_q[k-1];
        assign src_b[k] = opb_q[k-1];
        assign src_r[k] = res_q[k-1];
    end

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin : ready_chain
        ld         = '0;
        ld[NS-1]   = ~vld_q[NS-1] | bus.out_ready;
        for (int k = NS - 2; k >= 0; k--) begin
            ld[k] = ~vld_q[k] | ld[k+1];
        end
    end

    // Each stage ripples its own CW-bit segment; consumed operand bits are zeroed so the
    // deskew registers only carry what is still to be added.
    always_comb begin : seg_add
        carry = 1'b0;
        idx   = 0;
`ifdef RCA_OVF_EN
        msb_ci = 1'b0;
`endif
        for (int k = 0; k < NS; k++) begin
            res_d[k] = src_r[k];
            opa_d[k] = src_a[k];
            opb_d[k] = src_b[k];
            carry    = src_c[k];
            for (int i = 0; i < CW; i++) begin
                idx = k * CW + i;
`ifdef RCA_OVF_EN
                if (k == NS - 1 && i == CW - 1) msb_ci = carry;
`endif
                res_d[k][idx] = src_a[k][idx] ^ src_b[k][idx] ^ carry;
                carry         = (src_a[k][idx] & src_b[k][idx]) |
                                (carry & (src_a[k][idx] ^ src_b[k][idx]));
                opa_d[k][idx] = 1'b0;
                opb_d[k][idx] = 1'b0;
            end
            cy_d[k] = carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < NS; k++) begin
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
`ifdef RCA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (ld[k]) begin
                    vld_q[k] <= src_v[k];
                    // Data only moves with a valid token, so a bubble leaves it untouched.
                    if (src_v[k]) begin
                        res_q[k] <= res_d[k];
                        opa_q[k] <= opa_d[k];
                        opb_q[k] <= opb_d[k];
                        cy_q[k]  <= cy_d[k];
                    end
                end
            end
`ifdef RCA_OVF_EN
            if (ld[NS-1] && src_v[NS-1]) ovf_q <= msb_ci ^ cy_d[NS-1];
`endif
        end
    end

    assign bus.in_ready  = ld[0] & ~rst;
    assign bus.sum       = res_q[NS-1];
    assign bus.cout      = cy_q[NS-1];
    assign bus.out_valid = vld_q[NS-1];
`ifdef RCA_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
